// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display stage: core status codes,
// display FSM states and active-low seven-segment glyphs (gfedcba).
package calc_pkg;

    // Core status encodings as driven on the status bus.
    localparam logic [1:0] ST_ERRO  = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_PRINT = 2'b11;

    // Display frame-assembly FSM.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_COMMIT  = 2'd2,
        S_ERROR   = 2'd3
    } disp_state_e;

    // Active-low segment patterns, bit order gfedcba.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

endpackage

// File: rtl/calc_display_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-low gfedcba.
// Non-decimal codes 10..15 show a dash so garbage from the core is visible.
module bcd_to_seg7
    import calc_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    // Glyph lookup.
    always_comb begin
        seg_o = SEG_DASH;
        case (value_i)
            4'd0: seg_o = 7'h40;
            4'd1: seg_o = 7'h79;
            4'd2: seg_o = 7'h24;
            4'd3: seg_o = 7'h30;
            4'd4: seg_o = 7'h19;
            4'd5: seg_o = 7'h12;
            4'd6: seg_o = 7'h02;
            4'd7: seg_o = 7'h78;
            4'd8: seg_o = 7'h00;
            4'd9: seg_o = 7'h10;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/calc_display.sv
// Display stage of the calculator. Assembles the core's serial digit stream
// into a shadow frame, copies it to the visible frame only once every slot
// has been written, and scans the visible frame onto multiplexed displays.
//
// Stream protocol: there is no handshake. While status is PRINT, each cycle
// with 1 <= pos <= N_DIGITS carries one digit for slot pos-1; READY closes
// the frame, BUSY pauses it, ERRO latches the error display until reset.
module calc_display
    import calc_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_ZEROS = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          status,
    input  logic [3:0]          data,
    input  logic [3:0]          pos,
    output logic [N_DIGITS-1:0] an,
    output logic [7:0]          seg,
    output logic                frame_valid,
    output logic                error,
    output logic [1:0]          dbg_state
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [3:0]       POS_MAX  = 4'(N_DIGITS);

    disp_state_e          state_q, state_d;
    logic [N_DIGITS-1:0]  mask_q, mask_d;
    logic [3:0]           shadow_q  [N_DIGITS];
    logic [3:0]           visible_q [N_DIGITS];
    logic                 wr_en;
    logic                 commit;
    logic                 pos_ok;
    logic [IDX_W-1:0]     wr_slot;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [N_DIGITS-1:0]  an_q, an_d;
    logic [7:0]           seg_q, seg_d;
    logic [N_DIGITS-1:0]  lead_zero;
    logic [6:0]           glyph;

    assign pos_ok  = (pos != 4'd0) && (pos <= POS_MAX);
    assign wr_slot = IDX_W'(pos - 4'd1);

    // Next-state logic: frame capture, commit and sticky error.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (status == ST_PRINT) begin
                    state_d = S_CAPTURE;
                end else if (status == ST_ERRO) begin
                    state_d = S_ERROR;
                end
            end
            S_CAPTURE: begin
                case (status)
                    ST_PRINT: begin
                        if (pos_ok) begin
                            wr_en           = 1'b1;
                            mask_d[wr_slot] = 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (&mask_q) begin
                            state_d = S_COMMIT;
                        end else begin
                            mask_d  = '0;
                            state_d = S_IDLE;
                        end
                    end
                    ST_BUSY: begin
                        state_d = S_CAPTURE;
                    end
                    default: begin
                        mask_d  = '0;
                        state_d = S_ERROR;
                    end
                endcase
            end
            S_COMMIT: begin
                commit  = 1'b1;
                mask_d  = '0;
                // A new frame may start right behind the one being committed.
                state_d = (status == ST_PRINT) ? S_CAPTURE : S_IDLE;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and write mask registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    // Shadow and visible frame buffers; visible only changes on commit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow_q[i]  <= 4'd0;
                visible_q[i] <= 4'd0;
            end
        end else begin
            if (wr_en) begin
                shadow_q[wr_slot] <= data;
            end
            if (commit) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    visible_q[i] <= shadow_q[i];
                end
            end
        end
    end

    // Refresh divider and scan index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Leading-zero map: a digit is blank when it and everything above is zero.
    always_comb begin
        logic nz_seen;
        nz_seen   = 1'b0;
        lead_zero = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            nz_seen      = nz_seen | (visible_q[i] != 4'd0);
            lead_zero[i] = ~nz_seen;
        end
        lead_zero[0] = 1'b0;
    end

    bcd_to_seg7 u_dec (
        .value_i (visible_q[idx_q]),
        .seg_o   (glyph)
    );

    // Pattern for the digit currently selected by the scan index.
    always_comb begin
        an_d  = ~(N_DIGITS'(1) << idx_q);
        seg_d = {1'b1, SEG_BLANK};
        if (state_q == S_ERROR) begin
            if (idx_q == IDX_W'(2)) begin
                seg_d[6:0] = SEG_E;
            end else if (idx_q == IDX_W'(1) || idx_q == IDX_W'(0)) begin
                seg_d[6:0] = SEG_R;
            end
        end else begin
            seg_d[6:0] = ((BLANK_ZEROS != 0) && lead_zero[idx_q]) ? SEG_BLANK : glyph;
            seg_d[7]   = ~((idx_q == '0) && (status == ST_BUSY));
        end
    end

    // Registered display drive, one cycle behind the scan index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_q  <= '1;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_valid = (state_q == S_COMMIT);
    assign error       = (state_q == S_ERROR);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_calc_display.sv
// Bench for calc_display: table of full frames with expected scan patterns for
// both blanking settings, plus directed sequences for abort, busy dp,
// last-write-wins, back-to-back frames, asynchronous reset and error display.
module tb_calc_display;
    import calc_pkg::*;

    localparam int ND  = 8;
    localparam int DIV = 4;

    logic       clock, reset;
    logic [1:0] status;
    logic [3:0] data, pos;
    logic [7:0] an, seg, an_nb, seg_nb;
    logic       fv, err, fv_nb, err_nb;
    logic [1:0] st, st_nb;

    calc_display #(.N_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_ZEROS(1)) dut (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an), .seg(seg), .frame_valid(fv), .error(err), .dbg_state(st)
    );

    calc_display #(.N_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_ZEROS(0)) dut_nb (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an_nb), .seg(seg_nb), .frame_valid(fv_nb), .error(err_nb), .dbg_state(st_nb)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    int n_cmp;
    int n_bad;
    logic [7:0] shown    [ND];
    logic [7:0] shown_nb [ND];
    logic       an_bad;

    typedef struct packed {
        logic [31:0] digits;
        logic [63:0] exp;
        logic [63:0] exp_nb;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic stream(input logic [31:0] digits, input int nslots);
        for (int k = 1; k <= nslots; k++) begin
            pos  = 4'(k);
            data = digits[4*(k-1) +: 4];
            step;
        end
    endtask

    task automatic send_frame(input string tag, input logic [31:0] digits,
                              input int nslots, input logic exp_fv);
        status = ST_PRINT; pos = 4'd0; data = 4'd0;
        step;
        stream(digits, nslots);
        status = ST_READY; pos = 4'd0; data = 4'd0;
        step;
        check($sformatf("%s fv_pulse", tag), fv, exp_fv);
        check($sformatf("%s fv_pulse_nb", tag), fv_nb, exp_fv);
        step;
        check($sformatf("%s fv_drop", tag), fv, 1'b0);
    endtask

    task automatic scan;
        for (int d = 0; d < ND; d++) begin
            shown[d]    = 8'h55;
            shown_nb[d] = 8'h55;
        end
        an_bad = 1'b0;
        repeat (ND*DIV + 4) begin
            step;
            for (int d = 0; d < ND; d++) begin
                if (an == ~(8'd1 << d))    shown[d]    = seg;
                if (an_nb == ~(8'd1 << d)) shown_nb[d] = seg_nb;
            end
            if (!$onehot(~an) || !$onehot(~an_nb)) an_bad = 1'b1;
        end
    endtask

    task automatic check_scan(input string tag, input logic [63:0] exp, input logic [63:0] exp_nb);
        scan;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s seg d%0d", tag, d), shown[d], exp[8*d +: 8]);
            check($sformatf("%s seg_nb d%0d", tag, d), shown_nb[d], exp_nb[8*d +: 8]);
        end
        check($sformatf("%s an_onehot", tag), an_bad, 1'b0);
    endtask

    // ---------------- test ----------------
    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b1;
        status = ST_READY;
        data   = 4'd0;
        pos    = 4'd0;

        //             digits (d7..d0)  blanking on              blanking off
        vecs[0] = {32'h0000_0123, 64'hFFFF_FFFF_FFF9_A4B0, 64'hC0C0_C0C0_C0F9_A4B0};
        vecs[1] = {32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFC0, 64'hC0C0_C0C0_C0C0_C0C0};
        vecs[2] = {32'h0000_000C, 64'hFFFF_FFFF_FFFF_FFBF, 64'hC0C0_C0C0_C0C0_C0BF};
        vecs[3] = {32'h9876_5432, 64'h9080_F882_9299_B0A4, 64'h9080_F882_9299_B0A4};
        vecs[4] = {32'h0000_1050, 64'hFFFF_FFFF_F9C0_92C0, 64'hC0C0_C0C0_F9C0_92C0};
        vecs[5] = {32'hF000_0000, 64'hBFC0_C0C0_C0C0_C0C0, 64'hBFC0_C0C0_C0C0_C0C0};

        // Reset values.
        #3 reset = 1'b0;
        #1;
        check("rst an", an, 8'hFF);
        check("rst seg", seg, 8'hFF);
        check("rst fv", fv, 1'b0);
        check("rst err", err, 1'b0);
        check("rst state", st, 2'(S_IDLE));
        step;
        step;
        #2 reset = 1'b1;
        step;
        check("first tick an", an, 8'hFE);
        check("first tick seg", seg, 8'hC0);

        // Table-driven full frames.
        for (int i = 0; i < 6; i++) begin
            send_frame($sformatf("v%0d", i), vecs[i].digits, 8, 1'b1);
            check_scan($sformatf("v%0d", i), vecs[i].exp, vecs[i].exp_nb);
            if (i == 0) begin
                // Incomplete frame is dropped; 123 stays on screen.
                send_frame("abort", 32'h0009_8765, 5, 1'b0);
                check_scan("abort", vecs[0].exp, vecs[0].exp_nb);
            end
            if (i == 2) begin
                // Busy lights the decimal point on digit 0 only.
                status = ST_BUSY;
                check_scan("busy", {vecs[2].exp[63:8], 8'h3F}, {vecs[2].exp_nb[63:8], 8'h3F});
                status = ST_READY;
            end
        end

        // Last write wins; pos 0 / out of range and busy cycles do not write.
        status = ST_PRINT; pos = 4'd0; data = 4'd0;
        step;
        pos = 4'd1;  data = 4'd7; step;
        pos = 4'd1;  data = 4'd4; step;
        pos = 4'd0;  data = 4'd8; step;
        pos = 4'd9;  data = 4'd8; step;
        pos = 4'd15; data = 4'd8; step;
        stream(32'h0000_0000, 0);
        for (int k = 2; k <= 8; k++) begin
            pos = 4'(k); data = 4'd0; step;
        end
        status = ST_BUSY; pos = 4'd2; data = 4'd9; step;
        status = ST_READY; pos = 4'd0; data = 4'd0; step;
        check("lww fv_pulse", fv, 1'b1);
        step;
        check_scan("lww", 64'hFFFF_FFFF_FFFF_FF99, 64'hC0C0_C0C0_C0C0_C099);

        // Back-to-back frames: PRINT sampled during COMMIT.
        status = ST_PRINT; pos = 4'd0;
        step;
        stream(32'h0000_0001, 8);
        status = ST_READY; pos = 4'd0;
        step;
        check("b2b first fv", fv, 1'b1);
        status = ST_PRINT;
        step;
        check("b2b capture", st, 2'(S_CAPTURE));
        stream(32'h0000_0080, 8);
        status = ST_READY; pos = 4'd0;
        step;
        check("b2b second fv", fv, 1'b1);
        step;
        check_scan("b2b", 64'hFFFF_FFFF_FFFF_80C0, 64'hC0C0_C0C0_C0C0_80C0);

        // Asynchronous reset in the middle of a capture and a scan.
        status = ST_PRINT; pos = 4'd0;
        step;
        pos = 4'd1; data = 4'd5; step;
        pos = 4'd2; data = 4'd5; step;
        #2 reset = 1'b0;
        #1;
        check("midrst an", an, 8'hFF);
        check("midrst seg", seg, 8'hFF);
        check("midrst fv", fv, 1'b0);
        check("midrst err", err, 1'b0);
        check("midrst state", st_nb, 2'(S_IDLE));
        #1 reset = 1'b1;
        status = ST_READY; pos = 4'd0; data = 4'd0;
        step;
        check("postrst an", an, 8'hFE);
        check("postrst seg", seg, 8'hC0);
        check_scan("postrst", 64'hFFFF_FFFF_FFFF_FFC0, 64'hC0C0_C0C0_C0C0_C0C0);

        // Error during capture is sticky until reset.
        status = ST_PRINT; pos = 4'd0;
        step;
        pos = 4'd1; data = 4'd3; step;
        status = ST_ERRO; pos = 4'd0;
        step;
        check("err set", err, 1'b1);
        check("err set nb", err_nb, 1'b1);
        check("err state", st, 2'(S_ERROR));
        status = ST_READY;
        check_scan("err", 64'hFFFF_FFFF_FF86_AFAF, 64'hFFFF_FFFF_FF86_AFAF);
        status = ST_PRINT; pos = 4'd0;
        step;
        stream(32'h0000_0042, 8);
        status = ST_READY; pos = 4'd0;
        step;
        check("err no fv", fv, 1'b0);
        check("err persists", err, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("err cleared", err, 1'b0);
        check("err rst an", an, 8'hFF);
        #1 reset = 1'b1;
        step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_display.md
Name: calc_display

Overview:
- Downstream stage of the calculator core. Consumes the core's serial digit stream (`data`/`pos`/`status`) and assembles it into an 8-digit frame.
- Double-buffers the frame so a partly written number is never shown.
- Drives 8 multiplexed seven-segment displays with leading-zero blanking, an "Err" pattern and a busy indicator.

Parameters:
- N_DIGITS, 8, number of display digits; also the expected number of writes per frame.
- REFRESH_DIV, 50000, clock cycles each digit stays lit during scanning (minimum 2).
- BLANK_ZEROS, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- status  input  2  core status: 00 error, 01 busy, 10 ready, 11 printing
- data  input  4  BCD digit from the core
- pos  input  4  core position counter; while printing, a value of k (1..8) means `data` holds digit k-1 (LSD = digit 0)
- an  output  8  digit enables, active-low, one-hot; an[0] = rightmost digit
- seg  output  8  segments, active-low; seg[6:0] = gfedcba, seg[7] = dp
- frame_valid  output  1  one-cycle pulse when a new frame becomes visible
- error  output  1  high while the error pattern is shown

Behaviour:
- Reset (reset=0, asynchronous) values:
  - an=8'hFF, seg=8'hFF, frame_valid=0, error=0.
  - Shadow buffer, visible buffer and write mask cleared; FSM=IDLE; scan index=0; refresh counter=0.
- All inputs are sampled on the rising edge of clock.
- FSM states:
  - IDLE: status==11 -> CAPTURE; status==00 -> ERROR.
  - CAPTURE:
    - Each cycle with status==11 and 1<=pos<=8: shadow[pos-1]<=data and mask[pos-1]<=1.
    - pos==0 or pos>8 is ignored.
    - status==10 -> COMMIT if mask is all ones; otherwise discard the frame (clear mask) -> IDLE.
    - status==01 -> stay in CAPTURE without writing.
    - status==00 -> ERROR (shadow discarded).
  - COMMIT (exactly one cycle):
    - visible<=shadow, mask<=0, frame_valid=1 for that cycle -> IDLE.
    - Latency: status==10 is sampled at edge k; the visible buffer updates at edge k+1.
    - status==11 sampled during COMMIT -> next state CAPTURE, so back-to-back frames are not lost.
  - ERROR: error=1, display shows "Err"; exits only by reset.
- A rewrite of the same pos inside one frame overwrites the slot; last write wins.
- Scanning:
  - Refresh counter counts 0..REFRESH_DIV-1. On wrap, scan index increments modulo N_DIGITS.
  - `an` and `seg` are registered, updated the cycle after the index changes.
  - `an` is active-low one-hot for the current scan index.
- Segment decode:
  - BCD 0..9 decodes to standard glyphs.
  - Values 10..15 display "-" (segment g only).
  - Leading-zero blanking (BLANK_ZEROS=1): digits above the highest nonzero digit are blanked (seg[6:0]=all off). Digit 0 is always shown, so an all-zero frame shows "0".
- dp: seg[7] is lit only on digit 0 and only while status==01 (busy indicator); otherwise off.
- Error pattern: digit 2="E", digit 1="r", digit 0="r"; all other digits blank; dp off.
- Reset asserted mid-frame or mid-scan: immediate return to reset values. No partial frame survives.

Decomposition:
- Shared package calc_pkg holds:
  - Status encodings: ST_ERRO, ST_BUSY, ST_READY, ST_PRINT.
  - Display FSM state enum (IDLE, CAPTURE, COMMIT, ERROR).
  - Active-low segment constants: SEG_BLANK, SEG_DASH, SEG_E, SEG_R.
- One combinational sub-module bcd_to_seg7: 4-bit value in, 7-bit active-low gfedcba out. Values 10..15 map to dash.

Test Plan:
- Stream for 123 (REFRESH_DIV=4):
  - Stimulus: status=11, then pos=1..8 with data=3,2,1,0,0,0,0,0, then status=10.
  - Required: frame_valid pulses once, one cycle after status=10.
  - Scan shows digit0=8'hB0 ("3"), digit1=8'hA4 ("2"), digit2=8'hF9 ("1"), digits 3..7=8'hFF.
- Aborted frame:
  - Stimulus: visible=123; stream pos=1..5 only, then status=10.
  - Required: no frame_valid; display still shows 123.
- Error:
  - Stimulus: status=00 during CAPTURE.
  - Required: error=1 on the next cycle; scan shows digit2=8'h86 ("E"), digits 1,0=8'hAF ("r"); state persists until reset=0.
- Zero frame and blanking off:
  - Stimulus: all 8 slots written with 0.
  - Required: BLANK_ZEROS=1 shows only digit0=8'hC0 ("0"); BLANK_ZEROS=0 shows 8'hC0 on all 8 digits.
- Busy dp and out-of-range data:
  - Stimulus: status=01 in IDLE; frame with data=4'hC at pos=1.
  - Required: while status=01, digit0 has seg[7]=0; digit0 glyph for 4'hC is 8'hBF ("-").
- Reset mid-scan and mid-CAPTURE:
  - Stimulus: pulse reset=0 asynchronously between clock edges.
  - Required: an=8'hFF, seg=8'hFF, frame_valid=0, error=0 immediately; after release, first scan tick shows digit0 "0".
